// File: rtl/override_reg_pkg.sv
// Shared types and helpers for the override register bank.
package override_reg_pkg;

  // Command opcodes carried on wr_op; encodings 5..7 are no-ops.
  typedef enum logic [2:0] {
    OP_WRITE     = 3'd0,
    OP_ACC       = 3'd1,
    OP_FORCE     = 3'd2,
    OP_RELEASE   = 3'd3,
    OP_CLEAR_ALL = 3'd4,
    OP_NOP       = 3'd5
  } op_e;

  // Clear-all sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_e;

  // Debug view of one channel, widened to fixed sizes so it does not depend
  // on the bank parameters (channel width up to 32, timer width up to 16).
  localparam int DBG_W     = 32;
  localparam int DBG_TMR_W = 16;

  typedef struct packed {
    logic signed [DBG_W-1:0]     base;
    logic signed [DBG_W-1:0]     force_val;
    logic        [DBG_TMR_W-1:0] timer;
    logic                        forced;
    logic                        sat;
  } ch_state_t;

  // Result of a saturating add: clamped value plus a clamp indication.
  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Adds two sign-extended operands and clamps the sum to the signed range
  // of a w-bit value. Operands must already lie inside that range (w <= 32),
  // so the 64-bit sum can never wrap.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 w);
    logic signed [63:0] sum;
    logic signed [63:0] maxv;
    logic signed [63:0] minv;
    sat_res_t           r;
    sum   = a + b;
    maxv  = (64'sd1 <<< (w - 1)) - 64'sd1;
    minv  = -maxv - 64'sd1;
    r.sat = 1'b0;
    r.val = sum;
    if (sum > maxv) begin
      r.val = maxv;
      r.sat = 1'b1;
    end else if (sum < minv) begin
      r.val = minv;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/orb_channel.sv
// One channel of the override bank: base register with write/accumulate,
// a force/release override with optional self-release hold timer, and the
// registered output mux.
module orb_channel
  import override_reg_pkg::*;
#(
  parameter int                      W           = 16,
  parameter int                      TMR_W       = 8,
  parameter logic signed [W-1:0]     DEFAULT_VAL = 16'sh0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,     // accepted command addressed to this channel
  input  op_e                  op,
  input  logic signed [W-1:0]  data,
  input  logic [TMR_W-1:0]     hold,
  input  logic                 clr,     // sweep is clearing this channel this cycle
  output logic signed [W-1:0]  rd_val,
  output logic                 forced,
  output logic                 sat,
  output ch_state_t            dbg
);

  logic signed [W-1:0] base;
  logic signed [W-1:0] force_val;
  logic [TMR_W-1:0]    timer;
  sat_res_t            acc;
  logic                unused_acc_hi;

  // Saturating accumulate candidate, computed every cycle.
  always_comb begin
    acc = sat_add(64'(base), 64'(data), W);
  end

  // Upper bits of the wide sum are always a sign extension of the result.
  assign unused_acc_hi = ^acc.val[63:W];

  // Channel state. Order matters: the timer runs first, then a sweep clear or
  // a command overrides it, so a command landing on the expiry cycle wins.
  // The output mux samples pre-edge state, giving one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base      <= DEFAULT_VAL;
      force_val <= '0;
      timer     <= '0;
      forced    <= 1'b0;
      sat       <= 1'b0;
      rd_val    <= DEFAULT_VAL;
    end else begin
      rd_val <= forced ? force_val : base;

      if (timer != '0) begin
        timer <= timer - TMR_W'(1);
        if (timer == TMR_W'(1)) begin
          forced <= 1'b0;
        end
      end

      if (clr) begin
        base   <= DEFAULT_VAL;
        forced <= 1'b0;
        timer  <= '0;
        sat    <= 1'b0;
      end else if (sel) begin
        case (op)
          OP_WRITE: begin
            base <= data;
            sat  <= 1'b0;
          end
          OP_ACC: begin
            base <= acc.val[W-1:0];
            if (acc.sat) begin
              sat <= 1'b1;
            end
          end
          OP_FORCE: begin
            force_val <= data;
            forced    <= 1'b1;
            timer     <= hold;
          end
          OP_RELEASE: begin
            forced <= 1'b0;
            timer  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Debug view of the channel registers.
  always_comb begin
    dbg           = '0;
    dbg.base      = DBG_W'(base);
    dbg.force_val = DBG_W'(force_val);
    dbg.timer     = DBG_TMR_W'(timer);
    dbg.forced    = forced;
    dbg.sat       = sat;
  end

endmodule

// File: rtl/override_reg_bank.sv
// Bank of NCH signed fixed-point channel registers with per-channel
// force/release overrides. Holds command decode and the clear-all sweep.
//
// Handshake: a command transfers on a rising edge where wr_valid && wr_ready.
// wr_ready depends only on internal state (never on wr_valid); it is high in
// IDLE and low for exactly NCH cycles while a clear-all sweep runs. Commands
// to a channel index >= NCH and opcodes 5..7 are accepted and ignored.
module override_reg_bank
  import override_reg_pkg::*;
#(
  parameter int                  NCH         = 4,
  parameter int                  W           = 16,
  parameter int                  FRAC        = 8,
  parameter logic signed [W-1:0] DEFAULT_VAL = 16'sh0100,
  parameter int                  TMR_W       = 8,
  localparam int                 CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_op,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic signed [W-1:0]   wr_data,
  input  logic [TMR_W-1:0]      wr_hold,
  output logic [NCH*W-1:0]      rd_val,
  output logic [NCH-1:0]        forced,
  output logic [NCH-1:0]        sat,
  output fsm_e                  fsm_state,
  output ch_state_t [NCH-1:0]   dbg_ch
);

  // Reject parameter sets the datapath and debug view cannot represent.
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("NCH must be within 1..16");
  end
  if (W < 2 || W > DBG_W || FRAC < 0 || FRAC >= W) begin : g_bad_width
    $error("W must be within 2..32 and FRAC within 0..W-1");
  end
  if (TMR_W < 1 || TMR_W > DBG_TMR_W) begin : g_bad_tmr
    $error("TMR_W must be within 1..16");
  end

  fsm_e            state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic            accept;
  op_e             op;

  assign accept    = wr_valid && wr_ready;
  assign op        = op_e'(wr_op);
  assign fsm_state = state_q;

  // Sweep sequencer state and channel index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep sequencer next state; wr_ready is low for the whole sweep.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (accept && op == OP_CLEAR_ALL) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == CH_W'(NCH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    orb_channel #(
      .W           (W),
      .TMR_W       (TMR_W),
      .DEFAULT_VAL (DEFAULT_VAL)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .sel    (accept && (wr_ch == CH_W'(i))),
      .op     (op),
      .data   (wr_data),
      .hold   (wr_hold),
      .clr    ((state_q == SWEEP) && (idx_q == CH_W'(i))),
      .rd_val (rd_val[i*W +: W]),
      .forced (forced[i]),
      .sat    (sat[i]),
      .dbg    (dbg_ch[i])
    );
  end

endmodule

// File: tb/tb_override_reg_bank.sv
// Directed bench for override_reg_bank: a behavioural model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_override_reg_bank;
  import override_reg_pkg::*;

  localparam int NCH   = 4;
  localparam int W     = 16;
  localparam int TMR_W = 8;
  localparam int CH_W  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wr_valid;
  logic                wr_ready;
  logic [2:0]          wr_op;
  logic [CH_W-1:0]     wr_ch;
  logic signed [W-1:0] wr_data;
  logic [TMR_W-1:0]    wr_hold;
  logic [NCH*W-1:0]    rd_val;
  logic [NCH-1:0]      forced;
  logic [NCH-1:0]      sat;
  fsm_e                fsm_state;
  ch_state_t [NCH-1:0] dbg_ch;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  override_reg_bank #(
    .NCH(NCH), .W(W), .FRAC(8), .DEFAULT_VAL(16'sh0100), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_op(wr_op), .wr_ch(wr_ch), .wr_data(wr_data), .wr_hold(wr_hold),
    .rd_val(rd_val), .forced(forced), .sat(sat),
    .fsm_state(fsm_state), .dbg_ch(dbg_ch)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rd_ch(input int i);
    return rd_val[i*W +: W];
  endfunction

  // ---------------- behavioural model ----------------
  int  m_base[NCH];
  int  m_fv[NCH];
  int  m_timer[NCH];
  bit  m_forced[NCH];
  bit  m_sat[NCH];
  bit  m_ready;
  int  m_sweep_idx;
  logic [NCH*W-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_base[i] = 256; m_fv[i] = 0; m_timer[i] = 0;
      m_forced[i] = 0; m_sat[i] = 0;
    end
    m_ready = 1;
    m_sweep_idx = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [NCH*W-1:0] v;
    int ch, d, s;
    // Visible value after this edge is what the channel showed before it.
    for (int i = 0; i < NCH; i++)
      v[i*W +: W] = 16'(m_forced[i] ? m_fv[i] : m_base[i]);
    exp_q.push_back(v);
    for (int i = 0; i < NCH; i++) begin
      if (m_timer[i] > 0) begin
        m_timer[i]--;
        if (m_timer[i] == 0) m_forced[i] = 0;
      end
    end
    if (!m_ready) begin
      m_base[m_sweep_idx] = 256; m_forced[m_sweep_idx] = 0;
      m_timer[m_sweep_idx] = 0;  m_sat[m_sweep_idx] = 0;
      m_sweep_idx++;
      if (m_sweep_idx == NCH) m_ready = 1;
    end else if (wr_valid) begin
      ch = int'(wr_ch);
      d  = int'($signed(wr_data));
      if (wr_op == 3'd4) begin
        m_ready = 0;
        m_sweep_idx = 0;
      end else if (ch < NCH) begin
        case (wr_op)
          3'd0: begin m_base[ch] = d; m_sat[ch] = 0; end
          3'd1: begin
            s = m_base[ch] + d;
            if (s > 32767) begin s = 32767; m_sat[ch] = 1; end
            else if (s < -32768) begin s = -32768; m_sat[ch] = 1; end
            m_base[ch] = s;
          end
          3'd2: begin m_fv[ch] = d; m_forced[ch] = 1; m_timer[ch] = int'(wr_hold); end
          3'd3: begin m_forced[ch] = 0; m_timer[ch] = 0; end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [NCH-1:0] ef, es;
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        ef[i] = m_forced[i];
        es[i] = m_sat[i];
      end
      if (exp_q.size() == 0) begin
        chk("sb_queue_empty", 64'd0, 64'd1);
      end else begin
        chk("sb_rd_val", rd_val, exp_q.pop_front());
      end
      chk("sb_forced", forced, ef);
      chk("sb_sat", sat, es);
      chk("sb_wr_ready", wr_ready, m_ready);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input int ch, input logic [W-1:0] d,
                      input logic [TMR_W-1:0] h);
    int n = 0;
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", wr_ready, 1'b1);
    wr_valid = 1'b1;
    wr_op    = op;
    wr_ch    = CH_W'(ch);
    wr_data  = d;
    wr_hold  = h;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0;
    wr_op    = 3'd5;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    wr_valid = 1'b0; wr_op = 3'd5; wr_ch = '0; wr_data = '0; wr_hold = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // 1: reset state
    chk("t1_rd_all", rd_val, {4{16'h0100}});
    chk("t1_forced", forced, 4'b0000);
    chk("t1_sat", sat, 4'b0000);
    chk("t1_ready", wr_ready, 1'b1);

    // 2: write, saturating accumulate, write clears sat
    send(3'd0, 1, 16'h0200, 0);
    send(3'd1, 1, 16'h7F00, 0);
    chk("t2_sat_set", sat[1], 1'b1);
    idle(1);
    chk("t2_acc_clamp", rd_ch(1), 16'h7FFF);
    send(3'd0, 1, 16'h0010, 0);
    chk("t2_sat_clr", sat[1], 1'b0);
    idle(1);
    chk("t2_write", rd_ch(1), 16'h0010);
    send(3'd5, 1, 16'h1111, 0);
    send(3'd3, 1, 16'h0000, 0);
    idle(1);
    chk("t2_nop_release_noeffect", rd_ch(1), 16'h0010);
    chk("t2_unforced", forced[1], 1'b0);

    // 3: persistent force hides base writes; release reveals them
    send(3'd2, 2, 16'h1234, 0);
    send(3'd0, 2, 16'h0055, 0);
    idle(2);
    chk("t3_force_holds", rd_ch(2), 16'h1234);
    chk("t3_forced", forced[2], 1'b1);
    send(3'd3, 2, 16'h0000, 0);
    chk("t3_rel_forced", forced[2], 1'b0);
    chk("t3_rel_latency", rd_ch(2), 16'h1234);
    idle(1);
    chk("t3_reveal", rd_ch(2), 16'h0055);

    // 4: timed force for exactly 3 cycles, then reload on expiry cycle
    send(3'd2, 0, 16'hFF00, 3);
    chk("t4_dbg_timer", dbg_ch[0].timer, 16'd3);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("t4_hold", rd_ch(0), 16'hFF00);
    end
    idle(1);
    chk("t4_expire", rd_ch(0), 16'h0100);
    chk("t4_expire_flag", forced[0], 1'b0);
    send(3'd2, 0, 16'hFF00, 3);
    idle(2);
    send(3'd2, 0, 16'h0ABC, 5);
    chk("t4_reforce_flag", forced[0], 1'b1);
    chk("t4_old_val", rd_ch(0), 16'hFF00);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk("t4_rehold", rd_ch(0), 16'h0ABC);
    end
    idle(1);
    chk("t4_reexpire", rd_ch(0), 16'h0100);

    // 5: accumulate toward negative limit
    send(3'd1, 3, 16'h8000, 0);
    chk("t5_no_sat", sat[3], 1'b0);
    send(3'd1, 3, 16'h8000, 0);
    chk("t5_sat", sat[3], 1'b1);
    chk("t5_first", rd_ch(3), 16'h8100);
    idle(1);
    chk("t5_clamp", rd_ch(3), 16'h8000);

    // 6: clear-all sweep with a timed force in flight
    send(3'd2, 0, 16'h4444, 10);
    send(3'd4, 0, 16'h0000, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t6_ready_low", wr_ready, 1'b0);
      idle(1);
    end
    chk("t6_ready_high", wr_ready, 1'b1);
    idle(1);
    chk("t6_rd_all", rd_val, {4{16'h0100}});
    chk("t6_forced", forced, 4'b0000);
    chk("t6_sat", sat, 4'b0000);

    // 6b: reset in the middle of a sweep
    send(3'd0, 1, 16'h0777, 0);
    send(3'd2, 2, 16'h2222, 0);
    send(3'd4, 0, 16'h0000, 0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ready", wr_ready, 1'b1);
    chk("t6_rst_fsm", fsm_state, IDLE);
    chk("t6_rst_rd", rd_val, {4{16'h0100}});
    chk("t6_rst_forced", forced, 4'b0000);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send(3'd0, 3, 16'h0042, 0);
    idle(1);
    chk("t6_after_rst", rd_ch(3), 16'h0042);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
